// File: rtl/delay_sched_if.sv
// Handshake/bus bundle for delay_sched: two level requesters with samples,
// a delay setting, per-requester acks and the delayed output stream.
interface delay_sched_if;
    logic       req0;
    logic [3:0] in0;
    logic       req1;
    logic [3:0] in1;
    logic [3:0] dly;
    logic       ack0;
    logic       ack1;
    logic [3:0] out;
    logic       out_valid;
    logic       out_src;
    logic       busy;

    modport master (
        output req0, in0, req1, in1, dly,
        input  ack0, ack1, out, out_valid, out_src, busy
    );

    modport slave (
        input  req0, in0, req1, in1, dly,
        output ack0, ack1, out, out_valid, out_src, busy
    );
endinterface

// File: rtl/delay_sched.sv
// Two-requester round-robin scheduler that replays a captured sample after
// a programmable delay. Ports: clk, rst_n (async, active low), bus (slave).
module delay_sched (
    input  logic          clk,
    input  logic          rst_n,
    delay_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [3:0] hold, hold_n;
    logic       last_grant, last_grant_n;
    logic [3:0] out_q, out_n;
    logic       src_q, src_n;
    logic       ov_q, ov_n;
    logic       ack0_q, ack0_n;
    logic       ack1_q, ack1_n;
    logic       busy_q, busy_n;

    logic       any_req;
    logic       pick;
    logic       take;

    assign any_req = bus.req0 | bus.req1;
    // On a tie the requester not granted last wins.
    assign pick = (bus.req0 & bus.req1) ? ~last_grant : bus.req1;

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        hold_n       = hold;
        last_grant_n = last_grant;
        out_n        = out_q;
        src_n        = src_q;
        ov_n         = 1'b0;
        ack0_n       = 1'b0;
        ack1_n       = 1'b0;
        take         = 1'b0;

        unique case (state)
            IDLE: take = any_req;
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_n = DONE;
                    out_n   = hold;
                    src_n   = last_grant;
                    ov_n    = 1'b1;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
                // The edge that leaves DONE is also the first IDLE
                // grant opportunity, giving dly+2 cycles per transaction.
                take    = any_req;
            end
            default: state_n = IDLE;
        endcase

        if (take) begin
            state_n      = WAIT;
            cnt_n        = bus.dly;
            hold_n       = pick ? bus.in1 : bus.in0;
            last_grant_n = pick;
            ack0_n       = ~pick;
            ack1_n       = pick;
        end

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            hold       <= 4'd0;
            last_grant <= 1'b1;
            out_q      <= 4'd0;
            src_q      <= 1'b0;
            ov_q       <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            hold       <= hold_n;
            last_grant <= last_grant_n;
            out_q      <= out_n;
            src_q      <= src_n;
            ov_q       <= ov_n;
            ack0_q     <= ack0_n;
            ack1_q     <= ack1_n;
            busy_q     <= busy_n;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_src   = src_q;
    assign bus.out_valid = ov_q;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_delay_sched.sv
// Directed self-checking bench for delay_sched.
// Drives the interface master side and checks 1 ns after each rising edge.
module tb_delay_sched;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    delay_sched_if bus ();

    delay_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.in0  = 4'h0;
        bus.in1  = 4'h0;
        bus.dly  = 4'h0;
        #1;
        checks++;
        if ({bus.ack0, bus.ack1, bus.out_valid, bus.out_src, bus.busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 00000",
                     {bus.ack0, bus.ack1, bus.out_valid, bus.out_src, bus.busy});
        end
        checks++;
        if (bus.out !== 4'h0) begin
            errors++;
            $display("FAIL reset_out got %h exp 0", bus.out);
        end
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_dly3();
        bus.dly  = 4'd3;
        bus.in0  = 4'hA;
        bus.req0 = 1'b1;
        step();
        checks++;
        if ({bus.ack0, bus.ack1, bus.busy} !== 3'b101) begin
            errors++;
            $display("FAIL dly3_ack got %b exp 101", {bus.ack0, bus.ack1, bus.busy});
        end
        bus.req0 = 1'b0;
        bus.in0  = 4'h0;
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (bus.out_valid !== (k == 4)) begin
                errors++;
                $display("FAIL dly3_valid k=%0d got %b exp %b", k, bus.out_valid, (k == 4));
            end
            checks++;
            if (k >= 1 && bus.ack0 !== 1'b0) begin
                errors++;
                $display("FAIL dly3_ackdrop k=%0d got %b exp 0", k, bus.ack0);
            end
        end
        checks++;
        if ({bus.out, bus.out_src, bus.busy} !== {4'hA, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL dly3_out got %h/%b/%b exp a/0/0", bus.out, bus.out_src, bus.busy);
        end
    endtask

    task automatic test_dly0();
        bus.dly  = 4'd0;
        bus.in1  = 4'h5;
        bus.req1 = 1'b1;
        step();
        checks++;
        if ({bus.ack0, bus.ack1} !== 2'b01) begin
            errors++;
            $display("FAIL dly0_ack got %b exp 01", {bus.ack0, bus.ack1});
        end
        bus.req1 = 1'b0;
        step();
        checks++;
        if ({bus.out_valid, bus.out, bus.out_src, bus.busy} !== {1'b1, 4'h5, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL dly0_out got %b/%h/%b/%b exp 1/5/1/1",
                     bus.out_valid, bus.out, bus.out_src, bus.busy);
        end
        step();
        checks++;
        if ({bus.out_valid, bus.busy, bus.out} !== {1'b0, 1'b0, 4'h5}) begin
            errors++;
            $display("FAIL dly0_idle got %b/%b/%h exp 0/0/5", bus.out_valid, bus.busy, bus.out);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_out;
        logic       exp_src;
        bus.dly  = 4'd1;
        bus.in0  = 4'h1;
        bus.in1  = 4'h2;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        for (int s = 1; s <= 12; s++) begin
            step();
            exp_src = 1'(((s - 1) / 3) % 2);
            exp_out = exp_src ? 4'h2 : 4'h1;
            checks++;
            if ((s - 1) % 3 == 0) begin
                if ({bus.ack0, bus.ack1, bus.out_valid} !== {~exp_src, exp_src, 1'b0}) begin
                    errors++;
                    $display("FAIL b2b_ack s=%0d got %b exp %b", s,
                             {bus.ack0, bus.ack1, bus.out_valid}, {~exp_src, exp_src, 1'b0});
                end
            end else if ((s - 1) % 3 == 1) begin
                if ({bus.ack0, bus.ack1, bus.out_valid, bus.busy} !== 4'b0001) begin
                    errors++;
                    $display("FAIL b2b_wait s=%0d got %b exp 0001", s,
                             {bus.ack0, bus.ack1, bus.out_valid, bus.busy});
                end
            end else begin
                if ({bus.out_valid, bus.out, bus.out_src} !== {1'b1, exp_out, exp_src}) begin
                    errors++;
                    $display("FAIL b2b_out s=%0d got %b/%h/%b exp 1/%h/%b", s,
                             bus.out_valid, bus.out, bus.out_src, exp_out, exp_src);
                end
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        step();
        checks++;
        if ({bus.busy, bus.ack0, bus.ack1} !== 3'b000) begin
            errors++;
            $display("FAIL b2b_end got %b exp 000", {bus.busy, bus.ack0, bus.ack1});
        end
    endtask

    task automatic test_dly_change();
        bus.dly  = 4'd7;
        bus.in0  = 4'h3;
        bus.req0 = 1'b1;
        step();
        bus.req0 = 1'b0;
        bus.dly  = 4'd2;
        for (int k = 1; k <= 9; k++) begin
            step();
            checks++;
            if (bus.out_valid !== (k == 8)) begin
                errors++;
                $display("FAIL dlychg_valid k=%0d got %b exp %b", k, bus.out_valid, (k == 8));
            end
        end
        checks++;
        if ({bus.out, bus.out_src, bus.busy} !== {4'h3, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL dlychg_out got %h/%b/%b exp 3/0/0", bus.out, bus.out_src, bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        bus.dly  = 4'd5;
        bus.in1  = 4'hC;
        bus.req1 = 1'b1;
        step();
        bus.req1 = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ack0, bus.ack1, bus.out_valid, bus.out_src, bus.busy, bus.out} !== 9'b0) begin
            errors++;
            $display("FAIL rstmid_clear got %b exp 0",
                     {bus.ack0, bus.ack1, bus.out_valid, bus.out_src, bus.busy, bus.out});
        end
        bus.dly  = 4'd2;
        bus.in0  = 4'h9;
        bus.in1  = 4'h6;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({bus.ack0, bus.ack1, bus.busy} !== 3'b101) begin
            errors++;
            $display("FAIL rstmid_grant got %b exp 101", {bus.ack0, bus.ack1, bus.busy});
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if (bus.out_valid !== (k == 3)) begin
                errors++;
                $display("FAIL rstmid_valid k=%0d got %b exp %b", k, bus.out_valid, (k == 3));
            end
        end
        checks++;
        if ({bus.out, bus.out_src} !== {4'h9, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_out got %h/%b exp 9/0", bus.out, bus.out_src);
        end
    endtask

    task automatic test_dly15();
        bus.dly  = 4'd15;
        bus.in1  = 4'hF;
        bus.req1 = 1'b1;
        step();
        checks++;
        if (bus.ack1 !== 1'b1) begin
            errors++;
            $display("FAIL dly15_ack got %b exp 1", bus.ack1);
        end
        bus.req1 = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            step();
            checks++;
            if (bus.out_valid !== (k == 16) || bus.busy !== (k <= 16)) begin
                errors++;
                $display("FAIL dly15_valid k=%0d got %b/%b exp %b/%b", k,
                         bus.out_valid, bus.busy, (k == 16), (k <= 16));
            end
        end
        checks++;
        if ({bus.out, bus.out_src} !== {4'hF, 1'b1}) begin
            errors++;
            $display("FAIL dly15_out got %h/%b exp f/1", bus.out, bus.out_src);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_dly3();
        test_dly0();
        test_back_to_back();
        test_dly_change();
        test_reset_mid();
        test_dly15();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/delay_sched.md
DELAY_SCHED -- requirements
Module: delay_sched

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port req0, input, 1 bit: requester 0 level request.
REQ-004 SHALL have port in0, input, 4 bits: requester 0 sample.
REQ-005 SHALL have port req1, input, 1 bit: requester 1 level request.
REQ-006 SHALL have port in1, input, 4 bits: requester 1 sample.
REQ-007 SHALL have port dly, input, 4 bits: delay setting in cycles, 0..15.
REQ-008 SHALL have port ack0, output, 1 bit: one-cycle pulse when requester 0's sample is captured.
REQ-009 SHALL have port ack1, output, 1 bit: one-cycle pulse when requester 1's sample is captured.
REQ-010 SHALL have port out, output, 4 bits: delayed sample.
REQ-011 SHALL have port out_valid, output, 1 bit: one-cycle pulse marking a new out value.
REQ-012 SHALL have port out_src, output, 1 bit: requester index of the current out value.
REQ-013 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, DONE; every output SHALL be registered.
REQ-015 In IDLE with any req high at edge E0, SHALL grant one requester and do all of the following at that same edge: capture its in into hold, load cnt with dly, move to WAIT.
REQ-016 SHALL pulse ackN high for exactly the cycle following E0, for the granted requester only.
REQ-017 Arbitration SHALL be round-robin: single request granted directly; on simultaneous requests, grant the requester not granted last; last_grant resets to 1, so requester 0 wins the first tie.
REQ-018 In WAIT, cnt==0 at an edge SHALL move to DONE; otherwise cnt SHALL decrement by 1.
REQ-019 On entering DONE, SHALL load out<=hold, out_src<=grant, and set out_valid=1 for one cycle, visible after edge E0+dly+1.
REQ-020 DONE SHALL return to IDLE unconditionally after one cycle; next capture earliest at edge E0+dly+2.
REQ-021 out and out_src SHALL hold their values between DONE states.
REQ-022 dly SHALL be sampled only at grant; dly changes during WAIT SHALL be ignored.
REQ-023 req/in of either requester SHALL be ignored outside IDLE; a req still high on return to IDLE SHALL be treated as a new request.
REQ-024 A requester SHALL hold req and in stable until ack; the block SHALL not depend on in values at any edge other than E0.
REQ-025 busy SHALL be 1 in WAIT and DONE, and 0 in IDLE.

Reset
REQ-026 rst_n low SHALL immediately force: state=IDLE, cnt=0, hold=0, out=0, out_src=0, out_valid=0, ack0=0, ack1=0, busy=0, last_grant=1.
REQ-027 Reset mid-WAIT or mid-DONE SHALL discard the transaction; no out_valid or ack SHALL follow the release of reset.
REQ-028 The first edge after rst_n rises SHALL be able to grant.

Verification
REQ-029 Directed scenario: dly=3, req0=1, in0=4'hA at E0 -> ack0 high during cycle E0+1; out=4'hA, out_src=0, out_valid=1 only in the cycle after E0+4.
REQ-030 Directed scenario: dly=0, req1=1, in1=4'h5 -> out_valid after E0+1 with out=4'h5, out_src=1; busy low again after E0+2.
REQ-031 Directed scenario: req0 and req1 held high continuously, in0=4'h1, in1=4'h2, dly=1 -> outputs alternate 1,2,1,2 with out_src 0,1,0,1; transactions start 3 cycles apart.
REQ-032 Directed scenario: dly=7 at grant, dly changed to 2 during WAIT -> out_valid still after E0+8.
REQ-033 Directed scenario: rst_n pulsed low at E0+2 with dly=5 -> all outputs 0 immediately; no out_valid ever appears; next req is granted on the first edge after release.
REQ-034 Directed scenario: dly=15 -> out_valid after E0+16; cnt wraps neither below 0 nor above 15.
